// File: rtl/arbitro_rr_if.sv
// arbitro_rr_if: input/output FIFO handshake bundle for the round-robin arbiter
interface arbitro_rr_if #(
  parameter int NUM_PORTS      = 4,
  parameter int FIFO_WORD_SIZE = 10
);
  localparam int DEST_W = $clog2(NUM_PORTS);
  logic [NUM_PORTS-1:0]                empty;
  logic [NUM_PORTS-1:0]                almost_full;
  logic [NUM_PORTS*FIFO_WORD_SIZE-1:0] data_in;
  logic [NUM_PORTS-1:0]                pop;
  logic [NUM_PORTS-1:0]                push;
  logic [NUM_PORTS*FIFO_WORD_SIZE-1:0] data_out;
  logic [DEST_W-1:0]                   grant_id;
  logic                                busy;
  modport master(input empty, almost_full, data_in, output pop, push, data_out, grant_id, busy);
  modport slave(output empty, almost_full, data_in, input pop, push, data_out, grant_id, busy);
endinterface

// File: rtl/arbitro_rr.sv
// arbitro_rr: N-port arbiter routing input FIFO heads to per-destination output FIFOs
module arbitro_rr #(
  parameter int FIFO_WORD_SIZE = 10,
  parameter int NUM_PORTS      = 4,
  parameter int ARB_MODE       = 1
) (
  input  logic          clk,
  input  logic          reset,
  arbitro_rr_if.master  bus
);
  localparam int DEST_W = $clog2(NUM_PORTS);
  logic [DEST_W-1:0]                   dest [NUM_PORTS];
  logic [NUM_PORTS-1:0]                req;
  logic [DEST_W-1:0]                   rr_ptr, base, idx, gidx, gdest;
  logic                                found, grant;
  logic [FIFO_WORD_SIZE-1:0]           gword;
  logic [NUM_PORTS*FIFO_WORD_SIZE-1:0] data_n;
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
    assign dest[i] = bus.data_in[i*FIFO_WORD_SIZE+FIFO_WORD_SIZE-1 -: DEST_W];
    assign req[i]  = !bus.empty[i] && !bus.almost_full[dest[i]];
  end
  // pick the first qualified requester from the search base, then build pop and the next output word
  always_comb begin
    base  = (ARB_MODE == 1) ? rr_ptr : '0;
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = base + DEST_W'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    grant   = found && !reset;
    gword   = bus.data_in[gidx*FIFO_WORD_SIZE +: FIFO_WORD_SIZE];
    gdest   = gword[FIFO_WORD_SIZE-1 -: DEST_W];
    bus.pop = grant ? (NUM_PORTS'(1) << gidx) : '0;
    data_n  = '0;
    if (grant) data_n[gdest*FIFO_WORD_SIZE +: FIFO_WORD_SIZE] = gword;
  end
  // register the routed word, the served input and the round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.push     <= '0;
      bus.data_out <= '0;
      bus.grant_id <= '0;
      bus.busy     <= 1'b0;
      rr_ptr       <= '0;
    end else begin
      bus.push     <= grant ? (NUM_PORTS'(1) << gdest) : '0;
      bus.data_out <= data_n;
      bus.busy     <= grant;
      if (grant) begin
        bus.grant_id <= gidx;
        rr_ptr       <= gidx + DEST_W'(1);
      end
    end
  end
endmodule

// File: doc/arbitro_rr.md
Name: arbitro_rr

Overview:
- Parametrised N-input / N-output arbiter for the transaction layer, successor to the fixed 4-port priority arbiter.
- Selects one non-empty input FIFO per cycle, using either round-robin or fixed priority. It pops the selected FIFO and routes the head word to the output FIFO named by the word's destination field.
- Push and data toward the output FIFOs are registered, giving 1-cycle latency.
- Backpressure is per destination: an almost-full output FIFO stalls only the traffic headed to it, not the whole block.

Parameters:
- FIFO_WORD_SIZE, 10, word width in bits. The top DEST_W bits are the destination field.
- NUM_PORTS, 4, number of input and output FIFOs. Must be a power of 2, at least 2.
- ARB_MODE, 1, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin.
- DEST_W, $clog2(NUM_PORTS), localparam giving the destination field width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- empty  in  NUM_PORTS  empty[i] from input FIFO i.
- almost_full  in  NUM_PORTS  almost_full[j] from output FIFO j.
- data_in  in  NUM_PORTS*FIFO_WORD_SIZE  head word of input FIFO i in slice i. Show-ahead: valid whenever empty[i]=0.
- pop  out  NUM_PORTS  combinational read-enable to input FIFO i, one-hot or zero.
- push  out  NUM_PORTS  registered write-enable to output FIFO j, one-hot or zero.
- data_out  out  NUM_PORTS*FIFO_WORD_SIZE  registered word to output FIFO j in slice j.
- grant_id  out  DEST_W  registered index of the input served by the current push.
- busy  out  1  registered; 1 when any push is asserted this cycle.

Behaviour:
- Destination decode:
  - dest(i) = data_in slice i, bits [FIFO_WORD_SIZE-1 : FIFO_WORD_SIZE-DEST_W].
- Request qualification:
  - req[i] = !empty[i] && !almost_full[dest(i)].
  - A request whose destination is almost full is masked. Other inputs may still be granted in the same cycle.
- Grant (combinational):
  - At most one grant per cycle.
  - ARB_MODE=0: lowest-index requester wins.
  - ARB_MODE=1: the search starts at rr_ptr, ascending with wrap-around from NUM_PORTS-1 to 0. The first requester found wins.
- pop:
  - pop = one-hot grant. All zero when there is no requester or while reset=1.
- Round-robin pointer:
  - rr_ptr is a DEST_W-bit register.
  - On a grant to input g, rr_ptr <= (g+1) mod NUM_PORTS, wrapping naturally in DEST_W bits.
  - Holds when there is no grant. Resets to 0.
  - Unused when ARB_MODE=0.
- Output stage, on the rising edge after a grant to input g with destination d:
  - push[d]=1 and every other push bit is 0.
  - data_out slice d = data_in slice g as sampled at the grant cycle. Every other slice = 0.
  - grant_id = g, busy = 1.
- With no grant in the prior cycle: push=0, all data_out slices=0, busy=0, grant_id holds its previous value.
- Latency: pop to push is exactly 1 cycle. Sustained throughput is 1 word/cycle.
- Almost-full sampling:
  - almost_full is sampled in the grant cycle only.
  - The output FIFOs' almost-full threshold must leave at least 1 free entry for the in-flight push. This is the integration requirement.
- Simultaneous events:
  - Two inputs targeting the same destination: only the winner is popped; the loser waits.
  - Input i empty and almost_full changing in the same cycle: the current-cycle values apply, with no internal history.
- Reset (synchronous, active-high):
  - push=0, data_out=0, grant_id=0, busy=0, rr_ptr=0, and pop forced 0 combinationally.
  - Reset asserted mid-transfer: a push that would occur on the edge where reset is sampled high is suppressed. The word was already popped and is lost; this is accepted, and upstream must flush.
  - The first grant is possible in the cycle after reset deasserts.
- No state machine beyond rr_ptr and the output registers. No latches: every combinational output has a default.

Test Plan:
- Reset: reset=1 for 2 cycles with all inputs non-empty -> pop=0000, push=0000, data_out=0, busy=0. First pop=0001 in the cycle after deassert, with ARB_MODE=1 and rr_ptr=0.
- Routing: only input 1 non-empty with head 10'h2A5 (dest 2) -> pop=0010. Next cycle push=0100, data_out slice 2 = 10'h2A5, other slices 0, grant_id=1.
- Round-robin fairness: all 4 inputs continuously non-empty with distinct dests, no almost_full -> pops 0001, 0010, 0100, 1000, 0001... over 8 cycles. ARB_MODE=0 on the same stimulus -> pop=0001 every cycle.
- Per-destination backpressure: input 0 head dest 3, input 2 head dest 1, almost_full=1000 -> pop=0100 and next push=0010. Input 0 is not popped until almost_full[3] drops, then pop=0001.
- Contention: inputs 0 and 3 both target dest 0, rr_ptr=2 -> pop=1000 first, then pop=0001. Push[0] is high for 2 consecutive cycles carrying the two words in that order.
- Reset mid-stream: assert reset in the cycle after pop=0010 -> no push on that edge, rr_ptr=0 afterwards, and the next grant after deassert starts the search at input 0.
